// File: rtl/lbm_sweep_ctrl_if.sv
// Handshake and bus signals of the LBM sweep controller.
// The slave modport is the controller side; the master modport is the side that
// requests timesteps and consumes the read/writeback stream.
interface lbm_sweep_ctrl_if;
  logic        start_in;
  logic        dp_ready_in;
  logic        busy_out;
  logic        done_out;
  logic        phase_out;
  logic        rd_en_out;
  logic [15:0] rd_addr_out;
  logic        valid_out;
  logic [15:0] wb_addr_out;
  logic [7:0]  x_out;
  logic [7:0]  y_out;
  logic        edge_out;
  logic [15:0] step_count_out;

  modport master (
    output start_in, dp_ready_in,
    input  busy_out, done_out, phase_out, rd_en_out, rd_addr_out, valid_out,
    input  wb_addr_out, x_out, y_out, edge_out, step_count_out
  );

  modport slave (
    input  start_in, dp_ready_in,
    output busy_out, done_out, phase_out, rd_en_out, rd_addr_out, valid_out,
    output wb_addr_out, x_out, y_out, edge_out, step_count_out
  );
endinterface

// File: rtl/lbm_sweep_ctrl.sv
// Lattice-Boltzmann timestep sweep controller.
// One timestep = a collision sweep followed by a streaming sweep over all NX*NY cells,
// each sweep issuing row-major BRAM reads and draining an RD_LAT-deep tag pipeline.
// Optional feature: define LBM_BOUNDARY_FLAG_EN to flag boundary cells on edge_out;
// without it edge_out is tied low and no edge logic is built.
module lbm_sweep_ctrl #(
  parameter int unsigned NX     = 192,
  parameter int unsigned NY     = 192,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  lbm_sweep_ctrl_if.slave   sweep_io
);

  localparam logic [15:0] LastAddr  = 16'(NX * NY - 1);
  localparam logic [7:0]  XLast     = 8'(NX - 1);
  localparam logic [7:0]  YLast     = 8'(NY - 1);
  localparam logic [2:0]  DrainLast = 3'(RD_LAT - 1);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StCollIssue = 3'd1;
  localparam logic [2:0] StCollDrain = 3'd2;
  localparam logic [2:0] StStrmIssue = 3'd3;
  localparam logic [2:0] StStrmDrain = 3'd4;
  localparam logic [2:0] StDone      = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [2:0]  drain_q, drain_d;
  logic [15:0] step_q, step_d;

  logic issuing;
  logic rd_en;
  logic last_addr;

  // Tag pipeline: one stage per cycle of BRAM read latency.
  logic        vld_pipe_q  [RD_LAT];
  logic [15:0] addr_pipe_q [RD_LAT];
  logic [7:0]  x_pipe_q    [RD_LAT];
  logic [7:0]  y_pipe_q    [RD_LAT];

  // Read strobe: only in an ISSUE state and only when the datapath has room.
  always_comb begin
    issuing   = (state_q == StCollIssue) || (state_q == StStrmIssue);
    rd_en     = issuing && sweep_io.dp_ready_in;
    last_addr = (addr_q == LastAddr);
  end

  // Next-state logic for the sweep FSM, address/coordinate counters and step counter.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    drain_d = drain_q;
    step_d  = step_q;
    case (state_q)
      StIdle: begin
        if (sweep_io.start_in) state_d = StCollIssue;
      end
      StCollIssue, StStrmIssue: begin
        if (rd_en) begin
          if (last_addr) begin
            addr_d  = '0;
            x_d     = '0;
            y_d     = '0;
            drain_d = '0;
            state_d = (state_q == StCollIssue) ? StCollDrain : StStrmDrain;
          end else begin
            addr_d = addr_q + 16'd1;
            if (x_q == XLast) begin
              x_d = '0;
              y_d = y_q + 8'd1;
            end else begin
              x_d = x_q + 8'd1;
            end
          end
        end
      end
      StCollDrain, StStrmDrain: begin
        // Drain runs unconditionally so in-flight reads always reach writeback.
        if (drain_q == DrainLast) begin
          state_d = (state_q == StCollDrain) ? StStrmIssue : StDone;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      StDone: begin
        step_d  = step_q + 16'd1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and counter state.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      drain_q <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      drain_q <= drain_d;
      step_q  <= step_d;
    end
  end

  // Shift read tags down the pipeline every cycle so writeback lines up with BRAM data.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        vld_pipe_q[i]  <= 1'b0;
        addr_pipe_q[i] <= '0;
        x_pipe_q[i]    <= '0;
        y_pipe_q[i]    <= '0;
      end
    end else begin
      vld_pipe_q[0]  <= rd_en;
      addr_pipe_q[0] <= addr_q;
      x_pipe_q[0]    <= x_q;
      y_pipe_q[0]    <= y_q;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1];
        addr_pipe_q[i] <= addr_pipe_q[i-1];
        x_pipe_q[i]    <= x_pipe_q[i-1];
        y_pipe_q[i]    <= y_pipe_q[i-1];
      end
    end
  end

`ifdef LBM_BOUNDARY_FLAG_EN
  logic edge_c;
  logic edge_pipe_q [RD_LAT];

  // Boundary cell: first/last column or first/last row.
  always_comb begin
    edge_c = (x_q == 8'd0) || (x_q == XLast) || (y_q == 8'd0) || (y_q == YLast);
  end

  // Boundary flag travels alongside the other read tags.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(RD_LAT); i++) edge_pipe_q[i] <= 1'b0;
    end else begin
      edge_pipe_q[0] <= edge_c;
      for (int i = 1; i < int'(RD_LAT); i++) edge_pipe_q[i] <= edge_pipe_q[i-1];
    end
  end

  assign sweep_io.edge_out = edge_pipe_q[RD_LAT-1] & vld_pipe_q[RD_LAT-1];
`else
  assign sweep_io.edge_out = 1'b0;
`endif

  assign sweep_io.busy_out       = (state_q != StIdle);
  assign sweep_io.done_out       = (state_q == StDone);
  assign sweep_io.phase_out      = (state_q == StStrmIssue) || (state_q == StStrmDrain);
  assign sweep_io.rd_en_out      = rd_en;
  assign sweep_io.rd_addr_out    = addr_q;
  assign sweep_io.valid_out      = vld_pipe_q[RD_LAT-1];
  assign sweep_io.wb_addr_out    = addr_pipe_q[RD_LAT-1];
  assign sweep_io.x_out          = x_pipe_q[RD_LAT-1];
  assign sweep_io.y_out          = y_pipe_q[RD_LAT-1];
  assign sweep_io.step_count_out = step_q;

endmodule

// File: tb/tb_lbm_sweep_ctrl.sv
// Self-checking bench for lbm_sweep_ctrl on a 4x3 lattice with RD_LAT=2.
// Expected reads and writebacks are pushed to queues from a lattice model when a
// timestep is requested and popped by a monitor as the DUT produces them.
module tb_lbm_sweep_ctrl;
  localparam int unsigned NX     = 4;
  localparam int unsigned NY     = 3;
  localparam int unsigned RD_LAT = 2;
  localparam int          Depth  = 12;
`ifdef LBM_BOUNDARY_FLAG_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  lbm_sweep_ctrl_if sweep_if ();

  lbm_sweep_ctrl #(
    .NX     (NX),
    .NY     (NY),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .sweep_io (sweep_if)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  int exp_steps = 0;

  int           exp_rd_q [$];
  logic [32:0]  exp_wb_q [$];  // {addr, x, y, edge}
  logic [RD_LAT-1:0] rd_hist = '0;

  // Model of one row-major sweep: expected read addresses and writeback tags.
  task automatic push_sweep();
    for (int a = 0; a < Depth; a++) begin
      logic [7:0] x;
      logic [7:0] y;
      logic       e;
      x = 8'(a % NX);
      y = 8'(a / NX);
      e = EdgeEn && (x == 0 || x == 8'(NX - 1) || y == 0 || y == 8'(NY - 1));
      exp_rd_q.push_back(a);
      exp_wb_q.push_back({16'(a), x, y, e});
    end
  endtask

  // Scoreboard monitor: pops expected reads/writebacks and checks pipeline latency.
  always @(negedge clk_in) begin
    if (rst_in || !mon_en) begin
      rd_hist = '0;
    end else begin
      checks++;
      if (sweep_if.valid_out !== rd_hist[RD_LAT-1]) begin
        errors++;
        $display("FAIL valid_latency: valid_out=%b required=%b", sweep_if.valid_out,
                 rd_hist[RD_LAT-1]);
      end
      if (sweep_if.rd_en_out === 1'b1) begin
        checks++;
        if (exp_rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: rd_addr=%0d required=no read", sweep_if.rd_addr_out);
        end else begin
          int ea;
          ea = exp_rd_q.pop_front();
          if (sweep_if.rd_addr_out !== 16'(ea)) begin
            errors++;
            $display("FAIL rd_addr: got=%0d required=%0d", sweep_if.rd_addr_out, ea);
          end
        end
      end
      if (sweep_if.valid_out === 1'b1) begin
        checks++;
        if (exp_wb_q.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected: wb_addr=%0d required=no writeback",
                   sweep_if.wb_addr_out);
        end else begin
          logic [32:0] ew;
          ew = exp_wb_q.pop_front();
          if ({sweep_if.wb_addr_out, sweep_if.x_out, sweep_if.y_out, sweep_if.edge_out} !== ew)
          begin
            errors++;
            $display("FAIL wb_tag: got addr=%0d x=%0d y=%0d edge=%b required addr=%0d x=%0d y=%0d edge=%b",
                     sweep_if.wb_addr_out, sweep_if.x_out, sweep_if.y_out, sweep_if.edge_out,
                     ew[32:17], ew[16:9], ew[8:1], ew[0]);
          end
        end
      end
      rd_hist = {rd_hist[RD_LAT-2:0], sweep_if.rd_en_out};
    end
  end

  function automatic logic [69:0] all_outs();
    return {sweep_if.busy_out, sweep_if.done_out, sweep_if.phase_out, sweep_if.rd_en_out,
            sweep_if.rd_addr_out, sweep_if.valid_out, sweep_if.wb_addr_out, sweep_if.x_out,
            sweep_if.y_out, sweep_if.edge_out, sweep_if.step_count_out};
  endfunction

  task automatic test_reset();
    sweep_if.start_in    = 1'b0;
    sweep_if.dp_ready_in = 1'b1;
    rst_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_held_outputs: got=%h required=0", all_outs());
    end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_release_outputs: got=%h required=0", all_outs());
    end
    @(posedge clk_in); #1;
    exp_steps = 0;
    mon_en = 1'b1;
  endtask

  task automatic test_basic_step();
    int done_cyc = -1;
    int first_vld = -1;
    int nreads = 0;
    logic [31:0] first_tag = '0;
    push_sweep();
    push_sweep();
    for (int n = 0; n <= 34; n++) begin
      sweep_if.start_in    = (n == 0);
      sweep_if.dp_ready_in = 1'b1;
      @(negedge clk_in);
      if (sweep_if.rd_en_out && n >= 1 && n <= 12) nreads++;
      if (sweep_if.valid_out && first_vld < 0) begin
        first_vld = n;
        first_tag = {sweep_if.wb_addr_out, sweep_if.x_out, sweep_if.y_out};
      end
      if (sweep_if.done_out && done_cyc < 0) done_cyc = n;
      if (n == 1) begin
        checks++;
        if (sweep_if.busy_out !== 1'b1) begin
          errors++;
          $display("FAIL busy_cycle1: got=%b required=1", sweep_if.busy_out);
        end
      end
      if (n == 7) begin
        checks++;
        if (sweep_if.edge_out !== EdgeEn) begin
          errors++;
          $display("FAIL edge_addr4: got=%b required=%b", sweep_if.edge_out, EdgeEn);
        end
      end
      if (n == 8) begin
        checks++;
        if ({sweep_if.wb_addr_out, sweep_if.x_out, sweep_if.y_out, sweep_if.edge_out}
            !== {16'd5, 8'd1, 8'd1, 1'b0}) begin
          errors++;
          $display("FAIL addr5_tag: got addr=%0d x=%0d y=%0d edge=%b required 5 1 1 0",
                   sweep_if.wb_addr_out, sweep_if.x_out, sweep_if.y_out, sweep_if.edge_out);
        end
      end
      if (n == 14 || n == 15) begin
        checks++;
        if (sweep_if.phase_out !== (n == 15)) begin
          errors++;
          $display("FAIL phase_cycle%0d: got=%b required=%b", n, sweep_if.phase_out, n == 15);
        end
      end
      @(posedge clk_in); #1;
    end
    exp_steps++;
    checks++;
    if (nreads != 12) begin
      errors++;
      $display("FAIL coll_reads: got=%0d required=12", nreads);
    end
    checks++;
    if (first_vld != 3 || first_tag !== 32'd0) begin
      errors++;
      $display("FAIL first_valid: got cycle=%0d tag=%h required cycle=3 tag=0", first_vld,
               first_tag);
    end
    checks++;
    if (done_cyc != 29) begin
      errors++;
      $display("FAIL done_cycle: got=%0d required=29", done_cyc);
    end
    checks++;
    if (sweep_if.step_count_out !== 16'(exp_steps)) begin
      errors++;
      $display("FAIL step_count: got=%0d required=%0d", sweep_if.step_count_out, exp_steps);
    end
    checks++;
    if (exp_rd_q.size() != 0 || exp_wb_q.size() != 0) begin
      errors++;
      $display("FAIL basic_drained: got rd=%0d wb=%0d left required 0", exp_rd_q.size(),
               exp_wb_q.size());
    end
  endtask

  task automatic test_backpressure();
    int done_cyc = -1;
    push_sweep();
    push_sweep();
    for (int n = 0; n <= 40; n++) begin
      sweep_if.start_in    = (n == 0);
      sweep_if.dp_ready_in = !(n >= 4 && n <= 6);
      @(negedge clk_in);
      if (n >= 4 && n <= 6) begin
        checks++;
        if (sweep_if.rd_addr_out !== 16'd3 || sweep_if.rd_en_out !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold_c%0d: got addr=%0d rd_en=%b required addr=3 rd_en=0", n,
                   sweep_if.rd_addr_out, sweep_if.rd_en_out);
        end
      end
      if (sweep_if.done_out && done_cyc < 0) done_cyc = n;
      @(posedge clk_in); #1;
    end
    sweep_if.dp_ready_in = 1'b1;
    exp_steps++;
    checks++;
    if (done_cyc != 32) begin
      errors++;
      $display("FAIL stall_done_cycle: got=%0d required=32", done_cyc);
    end
    checks++;
    if (exp_rd_q.size() != 0 || exp_wb_q.size() != 0) begin
      errors++;
      $display("FAIL stall_drained: got rd=%0d wb=%0d left required 0", exp_rd_q.size(),
               exp_wb_q.size());
    end
    checks++;
    if (sweep_if.step_count_out !== 16'(exp_steps)) begin
      errors++;
      $display("FAIL stall_step_count: got=%0d required=%0d", sweep_if.step_count_out,
               exp_steps);
    end
  endtask

  task automatic test_reset_mid();
    int done_cyc = -1;
    int first_rd = -1;
    push_sweep();
    push_sweep();
    for (int n = 0; n <= 15; n++) begin
      sweep_if.start_in = (n == 0);
      if (n == 15) rst_in = 1'b1;
      @(negedge clk_in);
      if (n == 15) begin
        checks++;
        if (all_outs() !== '0) begin
          errors++;
          $display("FAIL midreset_outputs: got=%h required=0", all_outs());
        end
      end
      @(posedge clk_in); #1;
    end
    exp_rd_q.delete();
    exp_wb_q.delete();
    exp_steps = 0;
    rst_in = 1'b0;
    push_sweep();
    push_sweep();
    for (int n = 0; n <= 34; n++) begin
      sweep_if.start_in = (n == 0);
      @(negedge clk_in);
      if (sweep_if.rd_en_out && first_rd < 0) begin
        first_rd = n;
        checks++;
        if (sweep_if.rd_addr_out !== 16'd0) begin
          errors++;
          $display("FAIL restart_addr: got=%0d required=0", sweep_if.rd_addr_out);
        end
      end
      if (sweep_if.done_out && done_cyc < 0) done_cyc = n;
      @(posedge clk_in); #1;
    end
    exp_steps++;
    checks++;
    if (first_rd != 1 || done_cyc != 29) begin
      errors++;
      $display("FAIL restart_timing: got first_rd=%0d done=%0d required 1 29", first_rd,
               done_cyc);
    end
    checks++;
    if (sweep_if.step_count_out !== 16'(exp_steps)) begin
      errors++;
      $display("FAIL restart_step_count: got=%0d required=%0d", sweep_if.step_count_out,
               exp_steps);
    end
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    int d1 = -1;
    int d2 = -1;
    for (int k = 0; k < 4; k++) push_sweep();
    for (int n = 0; n <= 70; n++) begin
      sweep_if.start_in = (n < 60);
      @(negedge clk_in);
      if (sweep_if.done_out) begin
        ndone++;
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
      end
      if (n == 30 || n == 60) begin
        checks++;
        if (sweep_if.busy_out !== 1'b0 ||
            sweep_if.step_count_out !== 16'(exp_steps + (n == 30 ? 1 : 2))) begin
          errors++;
          $display("FAIL b2b_idle_c%0d: got busy=%b steps=%0d required busy=0 steps=%0d", n,
                   sweep_if.busy_out, sweep_if.step_count_out, exp_steps + (n == 30 ? 1 : 2));
        end
      end
      @(posedge clk_in); #1;
    end
    sweep_if.start_in = 1'b0;
    exp_steps += 2;
    checks++;
    if (ndone != 2 || d1 != 29 || d2 != 59) begin
      errors++;
      $display("FAIL b2b_done: got count=%0d at %0d,%0d required 2 at 29,59", ndone, d1, d2);
    end
    checks++;
    if (exp_rd_q.size() != 0 || exp_wb_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drained: got rd=%0d wb=%0d left required 0", exp_rd_q.size(),
               exp_wb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_step();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
